// File: rtl/fibo_pkg.sv
// Shared types and per-mode constants for the Fibonacci-style term stream generator.
// Pure declarations: no latency, no handshake.
package fibo_pkg;

  typedef enum logic [1:0] {
    MODE_FIB    = 2'd0,
    MODE_LUCAS  = 2'd1,
    MODE_PELL   = 2'd2,
    MODE_CUSTOM = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EMIT     = 3'd1,
    ST_DONE     = 3'd2,
    ST_ERROR    = 3'd3,
    ST_OVERFLOW = 3'd4
  } state_e;

  localparam int COEF_W = 2;

  localparam logic [1:0] FIB_T0      = 2'd0;
  localparam logic [1:0] FIB_T1      = 2'd1;
  localparam logic [1:0] LUCAS_T0    = 2'd2;
  localparam logic [1:0] LUCAS_T1    = 2'd1;
  localparam logic [1:0] PELL_T0     = 2'd0;
  localparam logic [1:0] PELL_T1     = 2'd1;

  localparam logic [COEF_W-1:0] FIB_COEF    = 2'd1;
  localparam logic [COEF_W-1:0] LUCAS_COEF  = 2'd1;
  localparam logic [COEF_W-1:0] PELL_COEF   = 2'd2;
  localparam logic [COEF_W-1:0] CUSTOM_COEF = 2'd1;

  function automatic logic [COEF_W-1:0] mode_coef(input mode_e m);
    logic [COEF_W-1:0] c;
    case (m)
      MODE_LUCAS: c = LUCAS_COEF;
      MODE_PELL:  c = PELL_COEF;
      MODE_CUSTOM: c = CUSTOM_COEF;
      default:    c = FIB_COEF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fibo_term_step.sv
// Next term = coef*curr + prev, evaluated two bits wider than the data path.
// Purely combinational; o_ovf flags a result that no longer fits DATA_WIDTH.
module fibo_term_step
  import fibo_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_prev,
  input  logic [DATA_WIDTH-1:0] i_curr,
  input  logic [COEF_W-1:0]     i_coef,
  output logic [DATA_WIDTH-1:0] o_next,
  output logic                  o_ovf
);

  logic [DATA_WIDTH+1:0] w_curr_ext;
  logic [DATA_WIDTH+1:0] w_scaled;
  logic [DATA_WIDTH+1:0] w_wide;

  // Coefficient is at most 3, so a shift-add replaces a full multiplier.
  assign w_curr_ext = {2'b00, i_curr};
  assign w_scaled   = (i_coef[0] ? w_curr_ext : '0) + (i_coef[1] ? (w_curr_ext << 1) : '0);
  assign w_wide     = w_scaled + {2'b00, i_prev};

  assign o_next = w_wide[DATA_WIDTH-1:0];
  assign o_ovf  = |w_wide[DATA_WIDTH+1:DATA_WIDTH];

endmodule

// File: rtl/fibo_stream_gen.sv
// Streams T(1)..T(order) of a second-order recurrence; first term 1 cycle after start, then 1/cycle.
// Output registers hold while out_ready=0; term overflow stops the stream in OVERFLOW until clear.
module fibo_stream_gen
  import fibo_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  seed0,
  input  logic [DATA_WIDTH-1:0]  seed1,
  input  logic [ORDER_WIDTH-1:0] order,
  input  logic                   clear,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ORDER_WIDTH-1:0] out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   error
);

  state_e                 r_state;
  logic [DATA_WIDTH-1:0]  r_prev;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [ORDER_WIDTH-1:0] r_index;
  logic [ORDER_WIDTH-1:0] r_order;
  logic [COEF_W-1:0]      r_coef;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;
  logic                   r_err;

  mode_e                  w_mode;
  logic [DATA_WIDTH-1:0]  w_t0;
  logic [DATA_WIDTH-1:0]  w_t1;
  logic                   w_bad_req;
  logic [DATA_WIDTH-1:0]  w_next;
  logic                   w_next_ovf;
  logic                   w_xfer;
  logic [ORDER_WIDTH-1:0] w_index_inc;

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_t0 = '0;
    w_t1 = '0;
    case (w_mode)
      MODE_LUCAS: begin
        w_t0 = DATA_WIDTH'(LUCAS_T0);
        w_t1 = DATA_WIDTH'(LUCAS_T1);
      end
      MODE_PELL: begin
        w_t0 = DATA_WIDTH'(PELL_T0);
        w_t1 = DATA_WIDTH'(PELL_T1);
      end
      MODE_CUSTOM: begin
        w_t0 = seed0;
        w_t1 = seed1;
      end
      default: begin
        w_t0 = DATA_WIDTH'(FIB_T0);
        w_t1 = DATA_WIDTH'(FIB_T1);
      end
    endcase
  end

  // An all-zero custom seed pair would stream zeros forever, so it is rejected like order 0.
  assign w_bad_req = (order == '0) ||
                     ((w_mode == MODE_CUSTOM) && (seed0 == '0) && (seed1 == '0));

  fibo_term_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_prev (r_prev),
    .i_curr (r_data),
    .i_coef (r_coef),
    .o_next (w_next),
    .o_ovf  (w_next_ovf)
  );

  assign w_xfer      = r_valid && out_ready;
  assign w_index_inc = r_index + ORDER_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_order <= '0;
      r_coef  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !clear) begin
            if (w_bad_req) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_EMIT;
              r_prev  <= w_t0;
              r_data  <= w_t1;
              r_index <= ORDER_WIDTH'(1);
              r_order <= order;
              r_coef  <= mode_coef(w_mode);
              r_valid <= 1'b1;
              r_last  <= (order == ORDER_WIDTH'(1));
              r_busy  <= 1'b1;
            end
          end
        end

        ST_EMIT: begin
          if (clear) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (r_last) begin
              r_state <= ST_DONE;
              r_data  <= '0;
              r_index <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_next_ovf) begin
              // Keep the last accepted term and its index visible for diagnosis.
              r_state <= ST_OVERFLOW;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_ovf   <= 1'b1;
            end else begin
              r_prev  <= r_data;
              r_data  <= w_next;
              r_index <= w_index_inc;
              r_last  <= (w_index_inc == r_order);
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end

        ST_ERROR: begin
          if (clear) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end
        end

        ST_OVERFLOW: begin
          if (clear) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_index <= '0;
            r_ovf   <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_data  <= '0;
          r_index <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ovf   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_index = r_index;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign error     = r_err;

endmodule

// File: tb/tb_fibo_stream_gen.sv
// Randomized and directed bench for fibo_stream_gen against a plain-arithmetic sequence model.
// A 64-bit instance covers normal streaming; an 8-bit instance covers term overflow.
module tb_fibo_stream_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [63:0] seed0 = '0;
  logic [63:0] seed1 = '0;
  logic [15:0] order = '0;
  bit          sel8 = 1'b0;

  logic [63:0] d_data;
  logic [15:0] d_index;
  logic        d_valid, d_last, d_busy, d_done, d_ovf, d_err;
  logic [7:0]  e_data;
  logic [15:0] e_index;
  logic        e_valid, e_last, e_busy, e_done, e_ovf, e_err;

  logic [63:0] m_data;
  logic [15:0] m_index;
  logic        m_valid, m_last, m_busy, m_done, m_ovf, m_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] got_data[$];
  int          got_idx[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          end_kind;
  logic [63:0] end_data;
  logic [15:0] end_idx;
  logic        end_valid;
  logic        done_after;
  int          stall_bad;

  logic [63:0] exp_q[$];
  bit          exp_err;
  bit          exp_ovf;

  always #5 clk = ~clk;

  fibo_stream_gen #(.DATA_WIDTH(64), .ORDER_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed0(seed0), .seed1(seed1),
    .order(order), .clear(clear), .out_data(d_data), .out_index(d_index),
    .out_valid(d_valid), .out_ready(out_ready), .out_last(d_last), .busy(d_busy),
    .done(d_done), .overflow(d_ovf), .error(d_err)
  );

  fibo_stream_gen #(.DATA_WIDTH(8), .ORDER_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
    .order(order), .clear(clear), .out_data(e_data), .out_index(e_index),
    .out_valid(e_valid), .out_ready(out_ready), .out_last(e_last), .busy(e_busy),
    .done(e_done), .overflow(e_ovf), .error(e_err)
  );

  always_comb begin
    if (sel8) begin
      m_data = {56'd0, e_data}; m_index = e_index; m_valid = e_valid; m_last = e_last;
      m_busy = e_busy; m_done = e_done; m_ovf = e_ovf; m_err = e_err;
    end else begin
      m_data = d_data; m_index = d_index; m_valid = d_valid; m_last = d_last;
      m_busy = d_busy; m_done = d_done; m_ovf = d_ovf; m_err = d_err;
    end
  end

  // Reference: iterate the recurrence in wide arithmetic, stop at the first term that does not fit.
  task automatic build_expect(input int md, input logic [63:0] s0, input logic [63:0] s1,
                              input int ord, input int width);
    logic [127:0] lim, a, b, n, c;
    lim = 128'd1 << width;
    exp_q.delete();
    exp_ovf = 1'b0;
    c = (md == 2) ? 128'd2 : 128'd1;
    case (md)
      1: begin a = 128'd2; b = 128'd1; end
      3: begin a = {64'd0, s0} & (lim - 1); b = {64'd0, s1} & (lim - 1); end
      default: begin a = 128'd0; b = 128'd1; end
    endcase
    exp_err = (ord == 0) || (md == 3 && a == 0 && b == 0);
    if (!exp_err) begin
      exp_q.push_back(b[63:0]);
      for (int k = 2; k <= ord; k++) begin
        n = c * b + a;
        if (n >= lim) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_q.push_back(n[63:0]);
        a = b;
        b = n;
      end
    end
  endtask

  // Pulses start on the selected instance and records every accepted term until the run ends.
  task automatic collect(input int pat, input int pct, input int budget);
    logic [63:0] p_data;
    logic [15:0] p_idx;
    logic        p_last;
    bit          p_stall;
    bit          rdy;
    int          cyc;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    end_kind = 0; stall_bad = 0; p_stall = 0; p_data = '0; p_idx = '0; p_last = 0;
    end_data = '0; end_idx = '0; end_valid = 0; done_after = 0;
    @(negedge clk);
    if (sel8) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      if (m_err) begin end_kind = 3; break; end
      if (m_ovf) begin
        end_kind = 2; end_data = m_data; end_idx = m_index; end_valid = m_valid;
        break;
      end
      if (m_done) begin
        end_kind = 1; end_data = m_data; end_valid = m_valid;
        @(negedge clk);
        done_after = m_done;
        break;
      end
      if (p_stall && (!m_valid || m_data !== p_data || m_index !== p_idx || m_last !== p_last))
        stall_bad++;
      rdy = (pat == 1) ? ((cyc - 1) % 3 == 0) : ($urandom_range(1, 100) <= pct);
      out_ready = rdy;
      if (m_valid && rdy) begin
        got_data.push_back(m_data); got_idx.push_back(int'(m_index));
        got_last.push_back(m_last); got_cyc.push_back(cyc);
      end
      p_stall = m_valid && !rdy; p_data = m_data; p_idx = m_index; p_last = m_last;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({d_valid, d_last, d_busy, d_done, d_ovf, d_err} !== 6'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b want 000000", {d_valid, d_last, d_busy, d_done, d_ovf, d_err});
    end
    n_checks++;
    if (d_data !== 64'd0 || d_index !== 16'd0) begin
      n_errors++; $display("FAIL reset_data: got data=%0d idx=%0d want 0/0", d_data, d_index);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fib10();
    logic [63:0] fib[10];
    fib = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    sel8 = 0; mode = 2'd0; order = 16'd10;
    build_expect(0, 0, 0, 10, 64);
    collect(0, 100, 200);
    n_checks++;
    if (got_data.size() !== 10) begin
      n_errors++; $display("FAIL fib10_count: got %0d want 10", got_data.size());
    end
    for (int i = 0; i < 10 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== fib[i] || got_data[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL fib10_term%0d: got %0d want %0d", i + 1, got_data[i], fib[i]);
      end
      n_checks++;
      if (got_idx[i] !== i + 1 || got_cyc[i] !== i + 1 || got_last[i] !== (i == 9)) begin
        n_errors++; $display("FAIL fib10_timing%0d: got idx=%0d cyc=%0d last=%0d want %0d/%0d/%0d",
                             i + 1, got_idx[i], got_cyc[i], got_last[i], i + 1, i + 1, (i == 9));
      end
    end
    n_checks++;
    if (end_kind !== 1 || end_valid !== 1'b0 || end_data !== 64'd0 || done_after !== 1'b0) begin
      n_errors++; $display("FAIL fib10_done: got kind=%0d valid=%0d data=%0d done_after=%0d want 1/0/0/0",
                           end_kind, end_valid, end_data, done_after);
    end
  endtask

  task automatic test_lucas_pell();
    logic [63:0] luc[5];
    logic [63:0] pel[6];
    logic [63:0] want;
    int          ord;
    luc = '{1, 3, 4, 7, 11};
    pel = '{1, 2, 5, 12, 29, 70};
    sel8 = 0;
    for (int t = 0; t < 2; t++) begin
      ord = (t == 0) ? 5 : 6;
      mode = (t == 0) ? 2'd1 : 2'd2;
      order = 16'(ord);
      build_expect(t + 1, 0, 0, ord, 64);
      collect(0, 100, 200);
      n_checks++;
      if (got_data.size() !== ord || end_kind !== 1) begin
        n_errors++; $display("FAIL seq%0d_shape: got n=%0d kind=%0d want %0d/1", t, got_data.size(), end_kind, ord);
      end
      for (int i = 0; i < ord && i < got_data.size(); i++) begin
        want = (t == 0) ? luc[i] : pel[i];
        n_checks++;
        if (got_data[i] !== want || got_data[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL seq%0d_term%0d: got %0d want %0d", t, i + 1, got_data[i], want);
        end
      end
    end
  endtask

  task automatic test_overflow8();
    sel8 = 1; mode = 2'd0; order = 16'd20;
    build_expect(0, 0, 0, 20, 8);
    collect(0, 100, 200);
    n_checks++;
    if (got_data.size() !== 13 || exp_q.size() !== 13 || !exp_ovf) begin
      n_errors++; $display("FAIL ovf8_count: got %0d model %0d want 13", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL ovf8_term%0d: got %0d want %0d", i + 1, got_data[i], exp_q[i]);
      end
    end
    n_checks++;
    if (end_kind !== 2 || end_idx !== 16'd13 || end_data !== 64'd233 || end_valid !== 1'b0) begin
      n_errors++; $display("FAIL ovf8_state: got kind=%0d idx=%0d data=%0d valid=%0d want 2/13/233/0",
                           end_kind, end_idx, end_data, end_valid);
    end
    pulse_clear();
    n_checks++;
    if (m_ovf !== 1'b0 || m_index !== 16'd0 || m_busy !== 1'b0) begin
      n_errors++; $display("FAIL ovf8_clear: got ovf=%0d idx=%0d busy=%0d want 0/0/0", m_ovf, m_index, m_busy);
    end
    sel8 = 0;
  endtask

  task automatic test_stall();
    sel8 = 0; mode = 2'd0; order = 16'd4;
    build_expect(0, 0, 0, 4, 64);
    collect(1, 0, 200);
    n_checks++;
    if (stall_bad !== 0 || end_kind !== 1 || got_data.size() !== 4) begin
      n_errors++; $display("FAIL stall_shape: got bad=%0d kind=%0d n=%0d want 0/1/4", stall_bad, end_kind, got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== i + 1) begin
        n_errors++; $display("FAIL stall_term%0d: got %0d@%0d want %0d@%0d", i + 1, got_data[i], got_idx[i], exp_q[i], i + 1);
      end
    end
  endtask

  task automatic test_error();
    sel8 = 0; mode = 2'd0; order = 16'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (d_err !== 1'b1 || d_valid !== 1'b0 || d_data !== 64'd0 || d_busy !== 1'b0) begin
      n_errors++; $display("FAIL err_order0: got err=%0d valid=%0d data=%0d busy=%0d want 1/0/0/0", d_err, d_valid, d_data, d_busy);
    end
    order = 16'd5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (d_err !== 1'b1 || d_busy !== 1'b0) begin
      n_errors++; $display("FAIL err_start_ignored: got err=%0d busy=%0d want 1/0", d_err, d_busy);
    end
    pulse_clear();
    n_checks++;
    if (d_err !== 1'b0) begin
      n_errors++; $display("FAIL err_clear: got err=%0d want 0", d_err);
    end
    mode = 2'd3; seed0 = '0; seed1 = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (d_err !== 1'b1) begin
      n_errors++; $display("FAIL err_zero_seeds: got err=%0d want 1", d_err);
    end
    pulse_clear();
    mode = 2'd0;
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    n_checks++;
    if (d_busy !== 1'b0 || d_valid !== 1'b0 || d_err !== 1'b0) begin
      n_errors++; $display("FAIL clear_priority: got busy=%0d valid=%0d err=%0d want 0/0/0", d_busy, d_valid, d_err);
    end
  endtask

  task automatic test_clear_abort();
    int n;
    int seen;
    sel8 = 0; mode = 2'd0; order = 16'd10; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (d_index !== 16'd3 && n < 20) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (d_index !== 16'd3 || d_data !== 64'd2) begin
      n_errors++; $display("FAIL abort_reach3: got idx=%0d data=%0d want 3/2", d_index, d_data);
    end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    seen = 0;
    n_checks++;
    if (d_valid !== 1'b0 || d_busy !== 1'b0 || d_index !== 16'd0 || d_data !== 64'd0) begin
      n_errors++; $display("FAIL abort_idle: got valid=%0d busy=%0d idx=%0d data=%0d want 0/0/0/0", d_valid, d_busy, d_index, d_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (d_done) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL abort_no_done: got %0d done cycles want 0", seen);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    sel8 = 0; mode = 2'd2; order = 16'd10; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({d_valid, d_last, d_busy, d_done, d_ovf, d_err} !== 6'b0 || d_data !== 64'd0 || d_index !== 16'd0) begin
      n_errors++; $display("FAIL reset_mid: got flags=%b data=%0d idx=%0d want 0", {d_valid, d_last, d_busy, d_done, d_ovf, d_err}, d_data, d_index);
    end
    reset = 1'b0; out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_done || d_ovf || d_err || d_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    int md, ord, pct, w;
    logic [63:0] s0, s1;
    for (int it = 0; it < 16; it++) begin
      md = $urandom_range(0, 3);
      sel8 = ($urandom_range(0, 2) == 0);
      w = sel8 ? 8 : 64;
      s0 = {$urandom, $urandom};
      s1 = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        s0 = 64'($urandom_range(0, 3));
        s1 = 64'($urandom_range(0, 3));
      end
      ord = $urandom_range(0, 30);
      pct = $urandom_range(30, 100);
      mode = 2'(md); seed0 = s0; seed1 = s1; order = 16'(ord);
      build_expect(md, s0, s1, ord, w);
      collect(0, pct, 1000);
      if (exp_err) begin
        n_checks++;
        if (end_kind !== 3) begin
          n_errors++; $display("FAIL rnd%0d_err: got kind=%0d want 3 (mode %0d ord %0d)", it, end_kind, md, ord);
        end
      end else begin
        n_checks++;
        if (got_data.size() !== exp_q.size() || end_kind !== (exp_ovf ? 2 : 1) || stall_bad !== 0) begin
          n_errors++; $display("FAIL rnd%0d_shape: got n=%0d kind=%0d bad=%0d want %0d/%0d/0",
                               it, got_data.size(), end_kind, stall_bad, exp_q.size(), exp_ovf ? 2 : 1);
        end
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
          n_checks++;
          if (got_data[i] !== exp_q[i] || got_idx[i] !== i + 1) begin
            n_errors++; $display("FAIL rnd%0d_term%0d: got %0d@%0d want %0d@%0d", it, i + 1, got_data[i], got_idx[i], exp_q[i], i + 1);
          end
        end
        if (exp_ovf) begin
          n_checks++;
          if (int'(end_idx) !== exp_q.size()) begin
            n_errors++; $display("FAIL rnd%0d_ovf_idx: got %0d want %0d", it, end_idx, exp_q.size());
          end
        end
      end
      pulse_clear();
    end
    sel8 = 0;
  endtask

  initial begin
    test_reset();
    test_fib10();
    test_lucas_pell();
    test_overflow8();
    test_stall();
    test_error();
    test_clear_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fibo_stream_gen.md
FIBO_STREAM_GEN -- requirements
Module: fibo_stream_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of seeds and sequence terms.
REQ-002 Parameter ORDER_WIDTH, default 16, width of order and term index.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a new sequence; sampled only in IDLE.
REQ-007 mode  input  2  recurrence select: 0 FIB, 1 LUCAS, 2 PELL, 3 CUSTOM; sampled with start.
REQ-008 seed0, seed1  input  DATA_WIDTH each  T(0), T(1) for CUSTOM; ignored otherwise.
REQ-009 order  input  ORDER_WIDTH  index of last term to emit; sampled with start.
REQ-010 clear  input  1  abort / leave ERROR or OVERFLOW.
REQ-011 out_data  output  DATA_WIDTH  current term T(out_index).
REQ-012 out_index  output  ORDER_WIDTH  index of current term.
REQ-013 out_valid  output  1; out_ready  input  1; out_last  output  1, marks index == order.
REQ-014 busy, done, overflow, error  output  1 each  status.

Function
REQ-015 Seeds/coefficient: FIB T0=0,T1=1,c=1; LUCAS T0=2,T1=1,c=1; PELL T0=0,T1=1,c=2; CUSTOM T0=seed0,T1=seed1,c=1.
REQ-016 Recurrence T(k+1) = c*T(k) + T(k-1), computed DATA_WIDTH+2 bits wide.
REQ-017 States: IDLE, EMIT, DONE, ERROR, OVERFLOW.
REQ-018 IDLE + start, order==0 or (CUSTOM and seed0==seed1==0) -> ERROR next cycle.
REQ-019 IDLE + start, valid inputs -> EMIT next cycle with out_index=1, out_data=T(1), out_valid=1 (latency 1 cycle).
REQ-020 EMIT: a transfer occurs on out_valid && out_ready; out_data/out_index/out_last SHALL hold stable while out_ready=0.
REQ-021 Transfer with out_index==order -> DONE; done=1 for exactly one cycle, then IDLE.
REQ-022 Transfer with out_index<order: next term computed; upper two bits nonzero -> OVERFLOW, term not emitted; else out_index+1, new term presented next cycle.
REQ-023 Sustained throughput one term per cycle while out_ready=1.
REQ-024 OVERFLOW: overflow=1, out_valid=0, out_data holds last emitted term, out_index holds its index; clear -> IDLE.
REQ-025 ERROR: error=1, out_valid=0, out_data=0; clear -> IDLE.
REQ-026 clear in EMIT aborts: IDLE next cycle, no done, pending term discarded.
REQ-027 clear has priority over start in same cycle; clear in IDLE/DONE has no effect.
REQ-028 start outside IDLE SHALL be ignored; busy=1 in EMIT only.
REQ-029 out_valid=0 and out_data=0 in IDLE, DONE, ERROR.

Reset
REQ-030 reset=1 SHALL, at the next clk edge and from any state, force IDLE and all outputs to 0.
REQ-031 Reset mid-EMIT discards the sequence; no done, overflow or error is reported.

Structure
REQ-032 Shared package fibo_pkg SHALL hold the mode enum, state enum, and per-mode seed/coefficient constants.
REQ-033 One combinational sub-module fibo_term_step SHALL compute next term and overflow flag from (prev, curr, coef).
REQ-034 fibo_stream_gen SHALL hold the FSM, term registers, index counter and handshake.

Verification
REQ-035 FIB, order=10, out_ready=1 -> 1,1,2,3,5,8,13,21,34,55 on consecutive cycles, out_last with 55, done one cycle later.
REQ-036 LUCAS order=5 -> 1,3,4,7,11; PELL order=6 -> 1,2,5,12,29,70.
REQ-037 DATA_WIDTH=8, FIB, order=20 -> terms through index 13 (233), then overflow=1, out_index=13; clear -> IDLE.
REQ-038 FIB order=4, out_ready toggled 1-0-0-1-... -> each term held stable during stalls, sequence 1,1,2,3 unchanged.
REQ-039 order=0 -> error=1 next cycle; CUSTOM seeds 0,0 -> error=1; clear -> IDLE, error=0.
REQ-040 clear at index 3 of FIB order=10 -> IDLE next cycle, no done; reset asserted mid-EMIT -> all outputs 0 after one edge.
